// File: rtl/axis_pixel_unpacker.sv
// axis_pixel_unpacker: unpacks 4 RGB pixels packed in 3 AXI-Stream words into one pixel per beat,
// keeping frame/line markers and flagging misaligned markers and wrong line lengths.
module axis_pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int CNT_W  = 16
) (
    input  logic             in_stream_aclk,
    input  logic             periph_reset,
    input  logic [31:0]      in_stream_tdata,
    input  logic [3:0]       in_stream_tkeep,
    input  logic             in_stream_tvalid,
    output logic             in_stream_tready,
    input  logic             in_stream_tuser,
    input  logic             in_stream_tlast,
    output logic [23:0]      out_stream_tdata,
    output logic             out_stream_tvalid,
    input  logic             out_stream_tready,
    output logic             out_stream_tuser,
    output logic             out_stream_tlast,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] line_count,
    output logic             align_err,
    output logic             len_err
);
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
    phase_t phase_q, phase_d;
    logic [23:0] res_q, res_d, data_q, data_d;
    logic valid_q, valid_d, user_q, user_d, last_q, last_d, pend_q, pend_d;
    logic [CNT_W-1:0] frame_q, frame_d, line_q, line_d, pix_q, pix_d;
    logic align_q, align_d, len_q, len_d;
    logic advance, in_hs, load, unused_keep;
    logic [31:0] w;

    assign w                 = in_stream_tdata;
    assign unused_keep       = ^in_stream_tkeep;
    assign advance           = !valid_q || out_stream_tready;
    assign in_stream_tready  = advance && phase_q != PH3;
    assign in_hs             = in_stream_tvalid && in_stream_tready;
    assign load              = advance && (phase_q == PH3 || in_hs);
    assign out_stream_tdata  = data_q;
    assign out_stream_tvalid = valid_q;
    assign out_stream_tuser  = user_q;
    assign out_stream_tlast  = last_q;
    assign frame_count       = frame_q;
    assign line_count        = line_q;
    assign align_err         = align_q;
    assign len_err           = len_q;

    always_comb begin
        phase_d = phase_q;
        res_d   = res_q;
        data_d  = data_q;
        valid_d = valid_q && !out_stream_tready;
        user_d  = user_q;
        last_d  = last_q;
        pend_d  = pend_q;
        frame_d = frame_q;
        line_d  = line_q;
        pix_d   = pix_q;
        align_d = align_q;
        len_d   = len_q;
        if (load) begin
            valid_d = 1'b1;
            if (phase_q == PH3) begin
                data_d  = res_q;
                user_d  = 1'b0;
                last_d  = pend_q;
                pend_d  = 1'b0;
                res_d   = '0;
                phase_d = PH0;
            end else begin
                user_d = in_stream_tuser;
                last_d = 1'b0;
                pend_d = 1'b0;
                // A start-of-frame always restarts packing, whatever phase we were in
                if (in_stream_tuser && phase_q != PH0)
                    align_d = 1'b1;
                if (in_stream_tuser || phase_q == PH0) begin
                    data_d  = w[23:0];
                    res_d   = {16'h0, w[31:24]};
                    phase_d = PH1;
                end else if (phase_q == PH1) begin
                    data_d  = {w[15:0], res_q[7:0]};
                    res_d   = {8'h0, w[31:16]};
                    phase_d = PH2;
                end else begin
                    data_d  = {w[7:0], res_q[15:0]};
                    res_d   = w[31:8];
                    phase_d = PH3;
                    pend_d  = in_stream_tlast;
                end
                // End-of-line anywhere but word 2 terminates the line on this pixel
                if (in_stream_tlast && phase_d != PH3) begin
                    last_d  = 1'b1;
                    res_d   = '0;
                    phase_d = PH0;
                    align_d = 1'b1;
                end
            end
            if (user_d)
                frame_d = frame_q + CNT_W'(1);
            line_d = (user_d ? '0 : line_q) + {{(CNT_W-1){1'b0}}, last_d};
            if (last_d) begin
                pix_d = '0;
                if (pix_q + CNT_W'(1) != CNT_W'(X_SIZE))
                    len_d = 1'b1;
            end else begin
                pix_d = pix_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            phase_q <= PH0;
            res_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            frame_q <= '0;
            line_q  <= '0;
            pix_q   <= '0;
            align_q <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            res_q   <= res_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            user_q  <= user_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            align_q <= align_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// tb_axis_pixel_unpacker: directed-vector bench for axis_pixel_unpacker with X_SIZE=8.
module tb_axis_pixel_unpacker;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] in_tdata;
    logic [3:0] in_tkeep;
    logic in_tvalid, in_tready, in_tuser, in_tlast;
    logic [23:0] out_tdata;
    logic out_tvalid, out_tready, out_tuser, out_tlast;
    logic [15:0] frame_count, line_count;
    logic align_err, len_err;
    int checks = 0;
    int failures = 0;
    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];

    axis_pixel_unpacker #(.X_SIZE(8), .CNT_W(16)) dut (
        .in_stream_aclk(clk), .periph_reset(rst),
        .in_stream_tdata(in_tdata), .in_stream_tkeep(in_tkeep),
        .in_stream_tvalid(in_tvalid), .in_stream_tready(in_tready),
        .in_stream_tuser(in_tuser), .in_stream_tlast(in_tlast),
        .out_stream_tdata(out_tdata), .out_stream_tvalid(out_tvalid),
        .out_stream_tready(out_tready), .out_stream_tuser(out_tuser),
        .out_stream_tlast(out_tlast), .frame_count(frame_count),
        .line_count(line_count), .align_err(align_err), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // out_stream_tready only changes exactly on a negedge, so this sample sees the next handshake
    always @(negedge clk) begin
        #1;
        if (!rst && out_tvalid && out_tready)
            got_q.push_back({out_tuser, out_tlast, out_tdata});
    end

    function automatic logic [25:0] px(input int i);
        return (i < got_q.size()) ? got_q[i] : '1;
    endfunction

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, px(i), exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [31:0] w, input logic u, input logic l);
        logic ok;
        in_tdata = w; in_tuser = u; in_tlast = l; in_tvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            #1 ok = in_tready;
            @(posedge clk);
            @(negedge clk);
        end
        in_tvalid = 1'b0; in_tuser = 1'b0; in_tlast = 1'b0;
        if (!ok)
            chk("push_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_tvalid = 1'b0; out_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tuser = 1'b0; in_tlast = 1'b0;
        in_tkeep = 4'hf; out_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", out_tvalid, 0);
        chk("rst_data", out_tdata, 0);
        chk("rst_frame", frame_count, 0);
        chk("rst_line", line_count, 0);
        chk("rst_errs", {align_err, len_err}, 0);
        chk("rst_ready", in_tready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Basic unpack
        push(32'h44332211, 0, 0);
        push(32'h88776655, 0, 0);
        push(32'hCCBBAA99, 0, 0);
        #1 chk("rdy_ph3", in_tready, 0);
        @(negedge clk);
        #1 chk("rdy_after_p3", in_tready, 1);
        chk("p3_data", out_tdata, 24'hCCBBAA);
        repeat (2) @(negedge clk);
        exp_q = '{{2'b00, 24'h332211}, {2'b00, 24'h665544}, {2'b00, 24'h998877}, {2'b00, 24'hCCBBAA}};
        cmp_q("unpack");

        // Backpressure: hold 5 cycles, then toggle 1010
        out_tready = 1'b0;
        fork
            begin
                push(32'h44332211, 0, 0);
                push(32'h88776655, 0, 0);
                push(32'hCCBBAA99, 0, 0);
            end
            begin
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    #2 chk("hold_valid", out_tvalid, 1);
                    chk("hold_data", out_tdata, 24'h332211);
                end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    out_tready = (i % 2 == 0);
                end
                @(negedge clk);
                out_tready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        exp_q = '{{2'b00, 24'h332211}, {2'b00, 24'h665544}, {2'b00, 24'h998877}, {2'b00, 24'hCCBBAA}};
        cmp_q("bp");

        // Two aligned lines of 8 pixels; byte stream 0,1,2,...
        do_reset();
        for (int i = 0; i < 12; i++)
            push(32'h03020100 + i * 32'h04040404, i == 0, i == 5 || i == 11);
        for (int k = 0; k < 16; k++)
            exp_q.push_back({k == 0, k == 7 || k == 15, 8'(3*k+2), 8'(3*k+1), 8'(3*k)});
        repeat (3) @(negedge clk);
        cmp_q("frame");
        chk("frame_lines", line_count, 2);
        chk("frame_frames", frame_count, 1);
        chk("frame_errs", {align_err, len_err}, 0);

        // tlast on word 1 of a line
        push(32'h44332211, 0, 0);
        push(32'h88776655, 0, 1);
        push(32'hCCBBAA99, 0, 0);
        repeat (3) @(negedge clk);
        exp_q = '{{2'b00, 24'h332211}, {2'b01, 24'h665544}, {2'b00, 24'hBBAA99}};
        cmp_q("misalign");
        chk("misalign_err", align_err, 1);
        chk("misalign_len", len_err, 1);
        chk("misalign_frames", frame_count, 1);

        // Short line: 4 pixels then tlast
        do_reset();
        push(32'h44332211, 0, 0);
        push(32'h88776655, 0, 0);
        push(32'hCCBBAA99, 0, 1);
        repeat (3) @(negedge clk);
        exp_q = '{{2'b00, 24'h332211}, {2'b00, 24'h665544}, {2'b00, 24'h998877}, {2'b01, 24'hCCBBAA}};
        cmp_q("short");
        chk("short_len", len_err, 1);
        chk("short_line", line_count, 1);
        chk("short_align", align_err, 0);

        // Reset in the middle of a stalled beat
        out_tready = 1'b0;
        push(32'h44332211, 0, 0);
        in_tdata = 32'h88776655; in_tvalid = 1'b1;
        #2 rst = 1'b1;
        #1 chk("mid_valid", out_tvalid, 0);
        chk("mid_data", out_tdata, 0);
        chk("mid_line", line_count, 0);
        chk("mid_errs", {align_err, len_err}, 0);
        @(negedge clk);
        rst = 1'b0; in_tvalid = 1'b0; out_tready = 1'b1;
        #1 chk("mid_ready", in_tready, 1);
        chk("mid_valid_after", out_tvalid, 0);
        repeat (2) @(negedge clk);
        chk("mid_no_beats", got_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
